// File: rtl/txfifo_pkg.sv
// Shared definitions for the UART transmit FIFO: default depth and the
// output-stage state encoding.
package txfifo_pkg;

  localparam int LGFLEN_DEFAULT = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/txfifo_mem.sv
// Simple dual-port byte RAM for the transmit FIFO. It has a synchronous write
// port and an asynchronous read port, and no reset.
module txfifo_mem #(
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] mem_q [(1 << AW)];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/txfifo.sv
// Byte FIFO that feeds a UART transmitter. The head byte is held on o_tx_data,
// and that byte counts toward the stored total until the transmitter takes it.
//
// Handshake: o_tx_wr is a valid signal, and !i_tx_busy is its ready. A byte
// moves on every rising edge where o_tx_wr=1 and i_tx_busy=0. While o_tx_wr=1,
// o_tx_data is held until that byte has moved.
module txfifo
  import txfifo_pkg::*;
#(
  parameter int LGFLEN = LGFLEN_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_clr,
  input  logic            i_wr,
  input  logic [7:0]      i_data,
  output logic            o_full,
  output logic            o_empty,
  output logic [LGFLEN:0] o_fill,
  output logic            o_overflow,
  output logic            o_tx_wr,
  output logic [7:0]      o_tx_data,
  input  logic            i_tx_busy,
  output tx_state_e       o_dbg_state
);

  localparam logic [LGFLEN:0]   FULL_CNT = {1'b1, {LGFLEN{1'b0}}};
  localparam logic [LGFLEN:0]   CNT_ONE  = (LGFLEN+1)'(1);
  localparam logic [LGFLEN-1:0] PTR_ONE  = LGFLEN'(1);

  tx_state_e         state_q, state_d;
  logic [LGFLEN-1:0] wr_ptr_q, wr_ptr_d;
  logic [LGFLEN-1:0] rd_ptr_q, rd_ptr_d;
  logic [LGFLEN:0]   fill_q, fill_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic              full;
  logic              wr_accept;
  logic              xfer;
  logic [LGFLEN-1:0] rd_addr;
  logic [7:0]        mem_rdata;

  assign full      = (fill_q == FULL_CNT);
  assign wr_accept = i_wr && !full;
  assign xfer      = (state_q == ST_PRESENT) && !i_tx_busy;
  // On a transfer, look one slot ahead so the next byte is ready on the same edge.
  assign rd_addr   = xfer ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

  txfifo_mem #(.AW(LGFLEN)) u_mem (
    .i_clk   (i_clk),
    .i_we    (wr_accept && !i_clr),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_data),
    .i_raddr (rd_addr),
    .o_rdata (mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q;
    tx_data_d  = tx_data_q;

    if (i_clr) begin
      state_d    = ST_IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (i_wr && full) overflow_d = 1'b1;
      if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;

      case ({wr_accept, xfer})
        2'b10:   fill_d = fill_q + CNT_ONE;
        2'b01:   fill_d = fill_q - CNT_ONE;
        default: fill_d = fill_q;
      endcase

      case (state_q)
        ST_IDLE: begin
          if (fill_q != '0) begin
            state_d   = ST_PRESENT;
            tx_data_d = mem_rdata;
          end
        end
        ST_PRESENT: begin
          if (xfer) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (fill_q > CNT_ONE) begin
              tx_data_d = mem_rdata;
            end else if (wr_accept) begin
              // The last byte leaves as a new one arrives. The RAM is not written
              // yet, so the new byte bypasses it.
              tx_data_d = i_data;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign o_full      = full;
  assign o_empty     = (fill_q == '0);
  assign o_fill      = fill_q;
  assign o_overflow  = overflow_q;
  assign o_tx_wr     = (state_q == ST_PRESENT);
  assign o_tx_data   = tx_data_q;
  assign o_dbg_state = state_q;

endmodule
